// File: rtl/fibo_gen_param_pkg.sv
// -----------------------------------------------------------------------------
// fibo_gen_param_pkg
// Purpose : shared FSM state encoding and default widths for the Fibonacci
//           stream generator (fibo_gen_param) and its datapath (fibo_step).
// Contents: FIBO_WIDTH_DEF / FIBO_CNT_W_DEF default widths, fibo_state_e.
// -----------------------------------------------------------------------------
package fibo_gen_param_pkg;

    localparam int unsigned FIBO_WIDTH_DEF = 8;
    localparam int unsigned FIBO_CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fibo_state_e;

endpackage : fibo_gen_param_pkg

// File: rtl/fibo_step.sv
// -----------------------------------------------------------------------------
// fibo_step
// Purpose : WIDTH+1-bit a/b register pair with adder. Bit WIDTH of each
//           register is a sticky overflow marker that propagates forward.
// Ports   : clk, reset   - clock, async active-high reset (a=b=0)
//           load         - capture seed_a/seed_b (priority over adv)
//           adv          - advance one term: a<=b, b<=a+b
//           seed_a/b     - seeds, WIDTH bits
//           a, b         - current/next term incl. sticky overflow bit
// -----------------------------------------------------------------------------
module fibo_step
    import fibo_gen_param_pkg::*;
#(
    parameter int unsigned WIDTH = FIBO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             adv,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    output logic [WIDTH:0]   a,
    output logic [WIDTH:0]   b
);

    logic [WIDTH:0] a_q, a_d;
    logic [WIDTH:0] b_q, b_d;
    logic [WIDTH:0] sum_c;

    // Next-state: carry out of the low WIDTH bits ORed with both sticky bits
    always_comb begin
        sum_c = {1'b0, a_q[WIDTH-1:0]} + {1'b0, b_q[WIDTH-1:0]};
        a_d   = a_q;
        b_d   = b_q;
        if (load) begin
            a_d = {1'b0, seed_a};
            b_d = {1'b0, seed_b};
        end else if (adv) begin
            a_d = b_q;
            b_d = {sum_c[WIDTH] | a_q[WIDTH] | b_q[WIDTH], sum_c[WIDTH-1:0]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a = a_q;
    assign b = b_q;

endmodule : fibo_step

// File: rtl/fibo_gen_param.sv
// -----------------------------------------------------------------------------
// fibo_gen_param
// Purpose : bounded Fibonacci term generator on a valid/ready stream with
//           start/done control and clean termination on WIDTH-bit overflow.
// Config  : `define FIBO_SEED_LOAD_EN adds seed_a/seed_b ports captured on the
//           accepted start; otherwise seeds are fixed at 0/1.
// Ports   : clk, reset (async, active-high)
//           start, num_terms       - run request (IDLE only, num_terms != 0)
//           seed_a, seed_b         - optional seeds
//           out_ready              - consumer ready
//           fibo_series/fibo_valid - current term and its valid
//           term_idx               - 0-based index of current term
//           busy, done, overflow   - RUN flag, end pulse, sticky overflow
// -----------------------------------------------------------------------------
module fibo_gen_param
    import fibo_gen_param_pkg::*;
#(
    parameter int unsigned WIDTH = FIBO_WIDTH_DEF,
    parameter int unsigned CNT_W = FIBO_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_terms,
`ifdef FIBO_SEED_LOAD_EN
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
`endif
    input  logic             out_ready,
    output logic [WIDTH-1:0] fibo_series,
    output logic             fibo_valid,
    output logic [CNT_W-1:0] term_idx,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    fibo_state_e      state_q;
    logic [CNT_W-1:0] num_terms_q;
    logic [CNT_W-1:0] term_idx_q;
    logic             fibo_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             overflow_q;

    logic [WIDTH-1:0] seed_a_c;
    logic [WIDTH-1:0] seed_b_c;
    logic [WIDTH:0]   a_c;
    logic [WIDTH:0]   b_c;
    logic             start_acc_c;
    logic             beat_c;
    logic             last_c;
    logic             unused_a_top_c;

`ifdef FIBO_SEED_LOAD_EN
    assign seed_a_c = seed_a;
    assign seed_b_c = seed_b;
`else
    assign seed_a_c = '0;
    assign seed_b_c = WIDTH'(1);
`endif

    assign start_acc_c    = (state_q == ST_IDLE) && start && (num_terms != '0);
    assign beat_c         = fibo_valid_q && out_ready;
    assign last_c         = (term_idx_q == (num_terms_q - CNT_W'(1)));
    // Overflow is decided from b before the advance, so a[WIDTH] is never read
    assign unused_a_top_c = a_c[WIDTH];

    fibo_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .clk    (clk),
        .reset  (reset),
        .load   (start_acc_c),
        .adv    (beat_c),
        .seed_a (seed_a_c),
        .seed_b (seed_b_c),
        .a      (a_c),
        .b      (b_c)
    );

    // Control FSM; an accepted beat whose successor (b) carries the sticky
    // overflow bit ends the run before that term is ever presented
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            num_terms_q  <= '0;
            term_idx_q   <= '0;
            fibo_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_acc_c) begin
                        state_q      <= ST_RUN;
                        num_terms_q  <= num_terms;
                        term_idx_q   <= '0;
                        overflow_q   <= 1'b0;
                        fibo_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (beat_c) begin
                        if (last_c || b_c[WIDTH]) begin
                            state_q      <= ST_DONE;
                            fibo_valid_q <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            overflow_q   <= ~last_c;
                        end else begin
                            term_idx_q <= term_idx_q + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    fibo_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

    assign fibo_series = a_c[WIDTH-1:0];
    assign fibo_valid  = fibo_valid_q;
    assign term_idx    = term_idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overflow    = overflow_q;

endmodule : fibo_gen_param

// File: tb/tb_fibo_gen_param.sv
// -----------------------------------------------------------------------------
// tb_fibo_gen_param
// Purpose : self-checking bench for fibo_gen_param (WIDTH=8, CNT_W=8).
//           Expected terms come from an unbounded-integer Fibonacci model;
//           a run presents terms until num_terms are out or a term no longer
//           fits in WIDTH bits. Honours FIBO_SEED_LOAD_EN for the seed ports.
// -----------------------------------------------------------------------------
module tb_fibo_gen_param;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] num_terms;
`ifdef FIBO_SEED_LOAD_EN
    logic [W-1:0]  seed_a;
    logic [W-1:0]  seed_b;
`endif
    logic          out_ready;
    logic [W-1:0]  fibo_series;
    logic          fibo_valid;
    logic [CW-1:0] term_idx;
    logic          busy;
    logic          done;
    logic          overflow;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    bit exp_ovf;

    always #5 clk = ~clk;

    fibo_gen_param #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_terms   (num_terms),
`ifdef FIBO_SEED_LOAD_EN
        .seed_a      (seed_a),
        .seed_b      (seed_b),
`endif
        .out_ready   (out_ready),
        .fibo_series (fibo_series),
        .fibo_valid  (fibo_valid),
        .term_idx    (term_idx),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    endtask

    // Reference: plain integer Fibonacci; a term is presentable only if < 2**W
    task automatic build_model(input int sa, input int sb, input int n);
        longint x = longint'(sa);
        longint y = longint'(sb);
        longint t;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            if (x >= (longint'(1) << W)) break;
            exp_q.push_back(int'(x));
            t = x + y;
            x = y;
            y = (t > 100000) ? 100000 : t;
        end
        exp_ovf = (exp_q.size() < n);
    endtask

    // One complete run; inputs driven and outputs sampled on the falling edge
    task automatic do_run(input int n, input int sa, input int sb, input int stall_pct,
                          input int stall_idx, input int stall_len, input bit poke);
        int idx     = 0;
        int cyc     = 0;
        int stalled = 0;
        bit fin     = 1'b0;
        bit rdy;
        build_model(sa, sb, n);
        @(negedge clk);
        start     = 1'b1;
        num_terms = CW'(n);
`ifdef FIBO_SEED_LOAD_EN
        seed_a = W'(sa);
        seed_b = W'(sb);
`endif
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("first_term_latency", fibo_valid, 1);
        chk("overflow_cleared", overflow, 0);
        while (!fin && cyc < 1000) begin
            rdy = 1'b1;
            if (done) begin
                fin = 1'b1;
                start = 1'b0;
                chk("terms_presented", idx, exp_q.size());
                chk("overflow_flag", overflow, exp_ovf);
                chk("valid_in_done", fibo_valid, 0);
                chk("busy_in_done", busy, 0);
                if (stall_pct == 0 && stall_idx < exp_q.size())
                    chk("rate_cycles", cyc, exp_q.size() + stall_len);
            end else begin
                chk("valid_running", fibo_valid, 1);
                chk("busy_running", busy, 1);
                if (idx >= exp_q.size()) begin
                    chk("extra_term", idx, exp_q.size() - 1);
                end else begin
                    chk("series", fibo_series, exp_q[idx]);
                    chk("term_idx", term_idx, idx);
                end
                if (idx == stall_idx && stalled < stall_len) begin
                    rdy = 1'b0;
                    stalled++;
                end else begin
                    rdy = ($urandom_range(0, 99) >= stall_pct);
                end
                if (rdy) idx++;
                start     = poke && (cyc == 2);
                num_terms = CW'($urandom_range(0, 5));
            end
            out_ready = rdy;
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) chk("done_timeout", fin, 1);
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int sa;
        int sb;
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        num_terms = '0;
`ifdef FIBO_SEED_LOAD_EN
        seed_a = '0;
        seed_b = '0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_series", fibo_series, 0);
        chk("rst_valid", fibo_valid, 0);
        chk("rst_idx", term_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;

        // basic, overflow, backpressure on term 5
        do_run(10, 0, 1, 0, -1, 0, 1'b0);
        do_run(20, 0, 1, 0, -1, 0, 1'b0);
        do_run(8, 0, 1, 0, 5, 3, 1'b0);

        // start with num_terms == 0 is ignored
        @(negedge clk);
        start = 1'b1;
        num_terms = '0;
        @(negedge clk);
        start = 1'b0;
        chk("zero_terms_busy", busy, 0);
        chk("zero_terms_valid", fibo_valid, 0);
        @(negedge clk);
        chk("zero_terms_done", done, 0);

        // start pulsed mid-run is ignored; boundary lengths around overflow
        do_run(12, 0, 1, 0, -1, 0, 1'b1);
        do_run(1, 0, 1, 0, -1, 0, 1'b0);
        do_run(14, 0, 1, 0, -1, 0, 1'b0);
        do_run(15, 0, 1, 0, -1, 0, 1'b0);

        // reset mid-run at term_idx 4
        @(negedge clk);
        start = 1'b1;
        num_terms = CW'(10);
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 50 && found == 0; k++) begin
            if (fibo_valid && term_idx == CW'(4)) found = 1;
            else @(negedge clk);
        end
        chk("reached_idx4", found, 1);
        reset = 1'b1;
        #1;
        chk("abort_series", fibo_series, 0);
        chk("abort_valid", fibo_valid, 0);
        chk("abort_idx", term_idx, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_overflow", overflow, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("no_done_after_abort", done, 0);
        end
        do_run(10, 0, 1, 0, -1, 0, 1'b0);

`ifdef FIBO_SEED_LOAD_EN
        do_run(6, 2, 1, 0, -1, 0, 1'b0);
`endif

        // randomized runs with random backpressure
        for (int r = 0; r < 10; r++) begin
`ifdef FIBO_SEED_LOAD_EN
            sa = int'($urandom_range(0, 255));
            sb = int'($urandom_range(0, 255));
`else
            sa = 0;
            sb = 1;
`endif
            do_run(int'($urandom_range(1, 20)), sa, sb, 30, -1, 0, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fibo_gen_param
